// File: rtl/led_stream_player.sv
// Valid/ready word player: each accepted word is shown on Led for HoldCycles_g cycles.
// Define LED_STREAM_PLAYER_PWM_EN to dim Led with an 8-bit PWM driven by Brightness.
module led_stream_player #(
  parameter int Width_g      = 4,
  parameter int HoldCycles_g = 12500000
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic [Width_g-1:0] In_Data,
  input  logic               In_Valid,
  output logic               In_Ready,
  input  logic               Clear,
  input  logic [7:0]         Brightness,
  output logic [Width_g-1:0] Led,
  output logic               Busy,
  output logic [15:0]        Words_Shown
);

  localparam int CntW_c = (HoldCycles_g > 1) ? $clog2(HoldCycles_g) : 1;
  localparam logic [CntW_c-1:0] Reload_c = CntW_c'(HoldCycles_g - 1);

  typedef enum logic {
    IDLE,
    SHOW
  } state_e;

  state_e             state_q;
  logic [CntW_c-1:0]  holdCnt_q;
  logic [Width_g-1:0] disp_q;
  logic [15:0]        words_q;
  logic               transfer;

  // Ready is held low during reset so nothing can be accepted before the first edge.
  assign In_Ready = Rst_n && !Clear && ((state_q == IDLE) || (holdCnt_q == '0));
  assign transfer = In_Valid && In_Ready;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q   <= IDLE;
      holdCnt_q <= '0;
      disp_q    <= '0;
      words_q   <= '0;
    end else if (Clear) begin
      state_q   <= IDLE;
      holdCnt_q <= '0;
      disp_q    <= '0;
    end else if (transfer) begin
      state_q   <= SHOW;
      holdCnt_q <= Reload_c;
      disp_q    <= In_Data;
      words_q   <= words_q + 16'd1;
    end else if (state_q == SHOW) begin
      if (holdCnt_q != '0) begin
        holdCnt_q <= holdCnt_q - CntW_c'(1);
      end else begin
        state_q <= IDLE;
      end
    end
  end

  assign Busy        = (state_q == SHOW);
  assign Words_Shown = words_q;

`ifdef LED_STREAM_PLAYER_PWM_EN
  logic [7:0] pwmCnt_q;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      pwmCnt_q <= 8'd0;
    end else begin
      pwmCnt_q <= pwmCnt_q + 8'd1;
    end
  end

  assign Led = disp_q & {Width_g{pwmCnt_q < Brightness}};
`else
  logic unusedBrightness;

  assign unusedBrightness = ^Brightness;
  assign Led              = disp_q;
`endif

endmodule

// File: doc/led_stream_player.md
LED_STREAM_PLAYER -- requirements
Module: led_stream_player

Interface
REQ-001 Parameter Width_g, default 4: data and LED width, 1..32.
REQ-002 Parameter HoldCycles_g, default 12500000: clock cycles each accepted word is displayed, >= 1.
REQ-003 Port Clk  in  1: single clock; all logic on rising edge.
REQ-004 Port Rst_n  in  1: reset, asynchronous, active-low.
REQ-005 Port In_Data  in  Width_g: word to display.
REQ-006 Port In_Valid  in  1: In_Data valid.
REQ-007 Port In_Ready  out  1: block accepts a word; transfer occurs when In_Valid=1 and In_Ready=1 on a rising edge.
REQ-008 Port Clear  in  1: synchronous abort and blank.
REQ-009 Port Brightness  in  8: PWM duty; used only when REQ-027 applies.
REQ-010 Port Led  out  Width_g: LED drive.
REQ-011 Port Busy  out  1: a word is currently in its hold period.
REQ-012 Port Words_Shown  out  16: count of accepted words.

Function
REQ-013 The state machine SHALL have exactly two states: IDLE and SHOW.
REQ-014 In IDLE, In_Ready SHALL be 1 (combinational from state, Clear, counter).
REQ-015 On a transfer in IDLE: SHALL latch In_Data into the display register, load the hold counter with HoldCycles_g-1, enter SHOW; Led SHALL show the new word on the cycle after the transfer edge.
REQ-016 In SHOW, the hold counter SHALL decrement by 1 per cycle; In_Ready SHALL be 0 while counter > 0.
REQ-017 In SHOW with counter = 0, In_Ready SHALL be 1; a transfer SHALL latch the new word, reload the counter and remain in SHOW (back-to-back words, no gap cycle).
REQ-018 In SHOW with counter = 0 and In_Valid = 0: SHALL enter IDLE; the display register SHALL keep its last word.
REQ-019 With HoldCycles_g = 1, one word SHALL be accepted per cycle while In_Valid = 1.
REQ-020 Busy SHALL be 1 exactly when state = SHOW.
REQ-021 Words_Shown SHALL increment by 1 per transfer, wrapping 65535 -> 0.
REQ-022 Clear = 1 SHALL force In_Ready = 0 in the same cycle and, on the edge, clear the display register to 0 and enter IDLE; Clear has priority over any transfer; Words_Shown is not affected.
REQ-023 In_Data and In_Valid changes while In_Ready = 0 SHALL have no effect.

Reset
REQ-024 While Rst_n = 0: state IDLE, display register 0, hold counter 0, Words_Shown 0, PWM counter 0; Led = 0, Busy = 0, In_Ready = 0.
REQ-025 Reset assertion mid-hold SHALL abort immediately (asynchronous); the first cycle after Rst_n deasserts SHALL present In_Ready = 1.

Configuration
REQ-026 The macro LED_STREAM_PLAYER_PWM_EN SHALL select PWM dimming.
REQ-027 Defined: 8-bit free-running PWM counter 0..255 wrapping; Led = display register AND pwm_on, with pwm_on = (PWM counter < Brightness); Brightness = 0 keeps Led = 0; Brightness = 255 gives 255/256 duty.
REQ-028 Not defined: Led = display register directly; Brightness ignored; no PWM counter.

Verification (Width_g = 4, HoldCycles_g = 4)
REQ-029 Single word: In_Data = 0xA, valid 1 cycle in IDLE -> Led = 0xA next cycle, Busy = 1 for 4 cycles, then IDLE with Led = 0xA, Words_Shown = 1.
REQ-030 Back-to-back: 0x1, 0x2, 0x3 held valid -> transfers exactly 4 cycles apart, In_Ready high 1 of every 4 cycles, Busy continuously 1, Words_Shown = 3.
REQ-031 Clear mid-hold: 0x5 accepted, Clear pulsed 2 cycles later with In_Valid = 1 -> no transfer on Clear edge, Led = 0, IDLE, In_Ready = 1 after Clear falls.
REQ-032 Async reset mid-hold: Rst_n low 1 cycle after accepting 0xF -> Led, Busy, In_Ready, Words_Shown = 0 without waiting for an edge.
REQ-033 Wrap: 65536 transfers -> Words_Shown = 0.
REQ-034 PWM (macro defined): Led register 0xF, Brightness = 64 -> Led = 0xF for 64 of every 256 cycles; Brightness = 0 -> Led = 0 throughout.
